// File: rtl/yoda_pkg.sv
// Shared types and defaults for the RGB window generator and the median stage downstream.
package yoda_pkg;

    localparam int DEFAULT_WINDOW_SIZE = 3;
    localparam int DEFAULT_DATA_WIDTH  = 8;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] red;
        logic [DEFAULT_DATA_WIDTH-1:0] green;
        logic [DEFAULT_DATA_WIDTH-1:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } win_state_t;

endpackage

// File: rtl/rgb_line_buffer.sv
// One image row of pixels: combinational read port, synchronous write port, no reset on the storage.
module rgb_line_buffer
    import yoda_pkg::*;
#(
    parameter int  DEPTH = 1024,
    parameter int  WIDTH = 24,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rgb_window_gen.sv
// Streaming KxK window generator over a raster RGB pixel stream using K-1 line buffers.
// Optional macro RGB_WINDOW_COUNT_EN adds o_win_count, the number of windows consumed this frame.
module rgb_window_gen
    import yoda_pkg::*;
#(
    parameter int WINDOW_SIZE = yoda_pkg::DEFAULT_WINDOW_SIZE,
    parameter int DATA_WIDTH  = yoda_pkg::DEFAULT_DATA_WIDTH,
    parameter int MAX_WIDTH   = 1024
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_start,
    input  logic [15:0]                                      i_img_width,
    input  logic [15:0]                                      i_img_height,
    input  logic [3*DATA_WIDTH-1:0]                          i_pix_in,
    input  logic                                             i_pix_in_valid,
    output logic                                             o_pix_in_ready,
    output logic [WINDOW_SIZE*WINDOW_SIZE*3*DATA_WIDTH-1:0]  o_win_out,
    output logic                                             o_win_valid,
    input  logic                                             i_win_ready,
    output logic                                             o_frame_done,
    output logic                                             o_cfg_err
`ifdef RGB_WINDOW_COUNT_EN
    ,
    output logic [31:0]                                      o_win_count
`endif
);

    localparam int K  = WINDOW_SIZE;
    localparam int PW = 3 * DATA_WIDTH;
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    win_state_t    r_state;
    win_state_t    w_next_state;
    logic [15:0]   r_width;
    logic [15:0]   r_col;
    logic [15:0]   r_row;
    logic [31:0]   r_pix_cnt;
    logic [31:0]   r_pix_total;
    logic [PW-1:0] r_win [K*K];
    logic          r_win_valid;
    logic          r_frame_done;
    logic          r_cfg_err;

    logic          w_cfg_ok;
    logic          w_start_ok;
    logic          w_accept;
    logic          w_last_pix;
    logic          w_produce;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] w_rd [K-1];
    logic [PW-1:0] w_wr [K-1];

    assign w_cfg_ok   = ({16'd0, i_img_width}  >= 32'(K)) &&
                        ({16'd0, i_img_width}  <= 32'(MAX_WIDTH)) &&
                        ({16'd0, i_img_height} >= 32'(K));
    assign w_start_ok = (r_state == ST_IDLE) && i_start && w_cfg_ok;

    assign o_pix_in_ready = (r_state == ST_RUN) && (!r_win_valid || i_win_ready);
    assign w_accept       = i_pix_in_valid && o_pix_in_ready;
    assign w_last_pix     = (r_pix_cnt == r_pix_total - 32'd1);
    assign w_produce      = (r_row >= 16'(K - 1)) && (r_col >= 16'(K - 1));
    assign w_addr         = r_col[AW-1:0];

    // Buffer 0 holds the oldest row; each accepted pixel pushes the column one buffer older.
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        if (j == K - 2) begin : g_youngest
            assign w_wr[j] = i_pix_in;
        end else begin : g_cascade
            assign w_wr[j] = w_rd[j+1];
        end

        rgb_line_buffer #(
            .DEPTH (MAX_WIDTH),
            .WIDTH (PW)
        ) u_line_buffer (
            .i_clk     (i_clk),
            .i_wr_en   (w_accept),
            .i_wr_addr (w_addr),
            .i_wr_data (w_wr[j]),
            .i_rd_addr (w_addr),
            .o_rd_data (w_rd[j])
        );
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_RUN;
            ST_RUN:   if (w_accept && w_last_pix) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!r_win_valid || i_win_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_width      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_pix_cnt    <= '0;
            r_pix_total  <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            for (int i = 0; i < K * K; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state      <= w_next_state;
            r_cfg_err    <= (r_state == ST_IDLE) && i_start && !w_cfg_ok;
            r_frame_done <= (r_state == ST_DRAIN) && (w_next_state == ST_IDLE);

            if (w_start_ok) begin
                r_width     <= i_img_width;
                r_pix_total <= {16'd0, i_img_width} * {16'd0, i_img_height};
                r_col       <= '0;
                r_row       <= '0;
                r_pix_cnt   <= '0;
            end

            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 32'd1;
                if (r_col == r_width - 16'd1) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
                // Columns left of K-1 after a row wrap are stale; w_produce keeps them from being flagged valid.
                for (int row = 0; row < K; row++) begin
                    for (int col = 0; col < K - 1; col++) begin
                        r_win[row*K+col] <= r_win[row*K+col+1];
                    end
                end
                for (int row = 0; row < K - 1; row++) begin
                    r_win[row*K+K-1] <= w_rd[row];
                end
                r_win[K*K-1] <= i_pix_in;
                r_win_valid  <= w_produce;
            end else if (i_win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < K * K; i++) begin : g_out
        assign o_win_out[i*PW +: PW] = r_win[i];
    end

    assign o_win_valid  = r_win_valid;
    assign o_frame_done = r_frame_done;
    assign o_cfg_err    = r_cfg_err;

`ifdef RGB_WINDOW_COUNT_EN
    logic [31:0] r_win_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_win_count <= '0;
        end else if (r_win_valid && i_win_ready) begin
            r_win_count <= r_win_count + 32'd1;
        end
    end

    assign o_win_count = r_win_count;
`endif

endmodule

// File: tb/tb_rgb_window_gen.sv
// Scoreboard bench for rgb_window_gen: a frame-level window model fills the queue, a monitor drains it.
// Checks o_win_count as well when RGB_WINDOW_COUNT_EN is defined.
module tb_rgb_window_gen;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int MAXW = 1024;
    localparam int PW   = 3 * DW;
    localparam int WINW = K * K * PW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     imgWidth;
    logic [15:0]     imgHeight;
    logic [PW-1:0]   pixIn;
    logic            pixInValid;
    logic            pixInReady;
    logic [WINW-1:0] winOut;
    logic            winValid;
    logic            winReady;
    logic            frameDone;
    logic            cfgErr;
`ifdef RGB_WINDOW_COUNT_EN
    logic [31:0]     winCount;
`endif

    int checks = 0;
    int errors = 0;
    int frameDoneCnt = 0;
    int negCycle = 0;
    int firstAcceptCycle = -1;
    int doneCycle = -1;
    int readyMode = 0;
    int expWins = 0;
    bit abortRun = 1'b0;

    logic [PW-1:0]   img [];
    logic [WINW-1:0] expQ [$];
    logic [WINW-1:0] gotWins [$];

    int firstIdx [K*K] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int lastIdx  [K*K] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

    always #5 clk = ~clk;

    rgb_window_gen #(
        .WINDOW_SIZE (K),
        .DATA_WIDTH  (DW),
        .MAX_WIDTH   (MAXW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_img_width    (imgWidth),
        .i_img_height   (imgHeight),
        .i_pix_in       (pixIn),
        .i_pix_in_valid (pixInValid),
        .o_pix_in_ready (pixInReady),
        .o_win_out      (winOut),
        .o_win_valid    (winValid),
        .i_win_ready    (winReady),
        .o_frame_done   (frameDone),
        .o_cfg_err      (cfgErr)
`ifdef RGB_WINDOW_COUNT_EN
        ,
        .o_win_count    (winCount)
`endif
    );

    task automatic checkOutput(input string name, input logic [WINW-1:0] actual, input logic [WINW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        abortRun = 1'b1;
        $display("[TB] FAIL %s: timed out, required the event within its cycle budget", name);
    endtask

    function automatic logic [WINW-1:0] refWindow(input int w, input int wr, input int wc);
        logic [WINW-1:0] v = '0;
        for (int rr = 0; rr < K; rr++)
            for (int cc = 0; cc < K; cc++)
                v[(rr*K+cc)*PW +: PW] = img[(wr+rr)*w + wc + cc];
        return v;
    endfunction

    function automatic logic [WINW-1:0] idxWindow(input int idx [K*K]);
        logic [WINW-1:0] v = '0;
        for (int i = 0; i < K * K; i++) v[i*PW +: PW] = {3{8'(idx[i])}};
        return v;
    endfunction

    task automatic buildImage(input int w, input int h, input bit useIndex);
        img = new[w*h];
        for (int i = 0; i < w * h; i++) img[i] = useIndex ? {3{8'(i)}} : PW'($urandom);
    endtask

    task automatic pushExpected(input int w, input int h);
        for (int wr = 0; wr + K <= h; wr++)
            for (int wc = 0; wc + K <= w; wc++)
                expQ.push_back(refWindow(w, wr, wc));
    endtask

    task automatic waitAccept();
        int t = 0;
        bit acc = 1'b0;
        while (!acc && !abortRun) begin
            @(negedge clk);
            acc = pixInReady;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 1000) reportTimeout("pixel accept");
        end
    endtask

    task automatic streamFrame(input int count, input bit gaps);
        for (int i = 0; i < count && !abortRun; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    pixInValid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            pixIn      = img[i];
            pixInValid = 1'b1;
            waitAccept();
        end
        pixInValid = 1'b0;
    endtask

    task automatic stallWindow();
        int t = 0;
        logic [WINW-1:0] held;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(winValid && gotWins.size() >= 1) && t < 1000);
        if (t >= 1000) begin
            reportTimeout("stall point");
        end else begin
            readyMode = 2;
            winReady  = 1'b0;
            held      = winOut;
            repeat (3) begin
                @(negedge clk);
                checkOutput("stall pix_in_ready", pixInReady, 0);
                checkOutput("stall win_valid", winValid, 1);
                checkOutput("stall win_out", winOut, held);
            end
            @(posedge clk);
            #1;
            readyMode = 0;
            winReady  = 1'b1;
        end
    endtask

    task automatic pokeStart();
        repeat (6) @(posedge clk);
        #1;
        imgWidth = 16'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("cfg_err on start in RUN", cfgErr, 0);
        @(posedge clk);
        #1;
        imgWidth = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitFrameDone(input int target);
        int t = 0;
        while (frameDoneCnt < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (frameDoneCnt < target) reportTimeout("frame_done");
        repeat (3) @(negedge clk);
        checkOutput("frame_done pulses", frameDoneCnt, target);
        checkOutput("windows outstanding", expQ.size(), 0);
        checkOutput("idle pix_in_ready", pixInReady, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int w, input int h, input bit useIndex, input bit gaps, input int mode);
        int doneTarget = frameDoneCnt + 1;
        buildImage(w, h, useIndex);
        expWins = (w - K + 1) * (h - K + 1);
        gotWins.delete();
        pushExpected(w, h);
        firstAcceptCycle = -1;
        imgWidth  = 16'(w);
        imgHeight = 16'(h);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fork
            streamFrame(w * h, gaps);
            begin
                if (mode == 1) stallWindow();
                else if (mode == 2) pokeStart();
            end
        join
        waitFrameDone(doneTarget);
        checkOutput("windows received", gotWins.size(), expWins);
`ifdef RGB_WINDOW_COUNT_EN
        checkOutput("win_count", winCount, expWins);
`endif
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " pix_in_ready"}, pixInReady, 0);
        checkOutput({tag, " win_valid"}, winValid, 0);
        checkOutput({tag, " win_out"}, winOut, '0);
        checkOutput({tag, " frame_done"}, frameDone, 0);
        checkOutput({tag, " cfg_err"}, cfgErr, 0);
`ifdef RGB_WINDOW_COUNT_EN
        checkOutput({tag, " win_count"}, winCount, 0);
`endif
    endtask

    task automatic checkIndexFrame(input string tag);
        if (gotWins.size() > 0) begin
            checkOutput({tag, " first window"}, gotWins[0], idxWindow(firstIdx));
            checkOutput({tag, " last window"}, gotWins[gotWins.size()-1], idxWindow(lastIdx));
        end
    endtask

    task automatic checkRejectedStart(input int w, input int h);
        imgWidth  = 16'(w);
        imgHeight = 16'(h);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("cfg_err pulse", cfgErr, 1);
        checkOutput("rejected pix_in_ready", pixInReady, 0);
        @(negedge clk);
        checkOutput("cfg_err cleared", cfgErr, 0);
        checkOutput("still idle pix_in_ready", pixInReady, 0);
        @(posedge clk);
        #1;
    endtask

    // Ready driver: always high, random, or left to the stall task.
    initial begin
        winReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 0) winReady = 1'b1;
            else if (readyMode == 1) winReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: a handshake seen mid-cycle completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            negCycle++;
            if (winValid && winReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected window", winValid, 0);
                end else begin
                    checkOutput("window", winOut, expQ.pop_front());
                    gotWins.push_back(winOut);
                end
            end
            if (frameDone) begin
                frameDoneCnt++;
                doneCycle = negCycle;
            end
            if (pixInValid && pixInReady && firstAcceptCycle < 0) firstAcceptCycle = negCycle;
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        imgWidth   = '0;
        imgHeight  = '0;
        pixIn      = '0;
        pixInValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] 5x4 index frame");
        applyStimulus(5, 4, 1'b1, 1'b0, 0);
        checkIndexFrame("index");

        $display("[TB] 5x4 index frame with downstream stall");
        applyStimulus(5, 4, 1'b1, 1'b0, 1);
        checkIndexFrame("stall");

        $display("[TB] rejected starts");
        checkRejectedStart(2, 4);
        checkRejectedStart(MAXW + 1, 4);
        checkRejectedStart(5, 2);

        $display("[TB] reset mid-frame");
        buildImage(5, 4, 1'b0);
        imgWidth  = 16'd5;
        imgHeight = 16'd4;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        streamFrame(8, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("mid-frame reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(5, 4, 1'b1, 1'b0, 0);
        checkIndexFrame("after reset");

        $display("[TB] start pulsed during RUN");
        applyStimulus(5, 4, 1'b0, 1'b0, 2);

        $display("[TB] random frames");
        readyMode = 1;
        for (int f = 0; f < 3; f++) begin
            applyStimulus($urandom_range(K, 9), $urandom_range(K, 6), 1'b0, 1'b1, 0);
        end
        readyMode = 0;
        @(posedge clk);
        #1;

        $display("[TB] 1024x3 back-to-back frame");
        applyStimulus(MAXW, 3, 1'b0, 1'b0, 0);
        checkOutput("full-width cycles", doneCycle - firstAcceptCycle, MAXW * 3 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
